ex_mdu: RTL

//  Parametrised iterative multiply/divide unit (RV32M: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) beside the ex stage ALU.
//  ex issues an M-extension op via a start pulse. The unit holds the pipeline through ex_hold_flag_o until the result is ready.
//  It then returns the result and rd address to ex for write-back through ex_mem.

---
 rtl/ex_mdu_pkg.sv | 33 +++
 rtl/mdu_negate.sv | 12 +
 rtl/ex_mdu.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared opcode encodings, FSM states and operand-signedness helpers for the M-extension unit.
package ex_mdu_pkg;

  localparam int unsigned OP_W = 3;
  localparam int unsigned RD_W = 5;

  localparam logic [6:0] FUNCT7_MDU = 7'b0000001;

  localparam logic [OP_W-1:0] OP_MUL    = 3'd0;
  localparam logic [OP_W-1:0] OP_MULH   = 3'd1;
  localparam logic [OP_W-1:0] OP_MULHSU = 3'd2;
  localparam logic [OP_W-1:0] OP_MULHU  = 3'd3;
  localparam logic [OP_W-1:0] OP_DIV    = 3'd4;
  localparam logic [OP_W-1:0] OP_DIVU   = 3'd5;
  localparam logic [OP_W-1:0] OP_REM    = 3'd6;
  localparam logic [OP_W-1:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic op1_signed(input logic [OP_W-1:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op2_signed(input logic [OP_W-1:0] op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module mdu_negate #(
  parameter int unsigned W = 32
) (
  input  logic         en,
  input  logic [W-1:0] a,
  output logic [W-1:0] y_c
);

  assign y_c = en ? (~a + W'(1)) : a;

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start_i,
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [RD_W-1:0] rd_addr_i,
  input  logic            kill_i,
  output logic            ex_hold_flag_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [RD_W-1:0] rd_addr_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  logic             accept;
  logic [OP_W-1:0]  op_q;
  logic [RD_W-1:0]  rd_q;
  logic [XLEN-1:0]  opb_q;
  logic [PW-1:0]    prod_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_res_q, neg_rem_q;
  logic [XLEN-1:0]  result_q;
  logic [RD_W-1:0]  rd_addr_q;

  // Issue-time operand signs, magnitudes and special-case divide detection
  logic            s1, s2, div_zero, div_ovf, special;
  logic [XLEN-1:0] abs1, abs2, special_res;

  assign s1       = op1_signed(op_i) & op1_i[XLEN-1];
  assign s2       = op2_signed(op_i) & op2_i[XLEN-1];
  assign div_zero = op_i[2] & (op2_i == '0);
  assign div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) & (op1_i == MIN_INT) & (op2_i == '1);
  assign special  = div_zero | div_ovf;
  assign special_res = div_zero ? (op_i[1] ? op1_i : '1) : (op_i[1] ? '0 : MIN_INT);

  mdu_negate #(.W(XLEN)) u_abs1 (.en(s1), .a(op1_i), .y_c(abs1));
  mdu_negate #(.W(XLEN)) u_abs2 (.en(s2), .a(op2_i), .y_c(abs2));

  // One iteration step: multiply keeps {acc, multiplier}, divide keeps {remainder, dividend/quotient}
  logic [XLEN:0] mul_sum, div_trial, div_diff;
  logic [PW-1:0] mul_next, div_next;

  assign mul_sum   = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next  = {mul_sum, prod_q[XLEN-1:1]};
  assign div_trial = prod_q[PW-1:XLEN-1];
  assign div_diff  = div_trial - {1'b0, opb_q};
  assign div_next  = {(div_diff[XLEN] ? div_trial[XLEN-1:0] : div_diff[XLEN-1:0]),
                      prod_q[XLEN-2:0], ~div_diff[XLEN]};

  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

  mdu_negate #(.W(PW))   u_fix_prod (.en(neg_res_q), .a(prod_q),             .y_c(prod_fix));
  mdu_negate #(.W(XLEN)) u_fix_quo  (.en(neg_res_q), .a(prod_q[XLEN-1:0]),   .y_c(quo_fix));
  mdu_negate #(.W(XLEN)) u_fix_rem  (.en(neg_rem_q), .a(prod_q[PW-1:XLEN]),  .y_c(rem_fix));

  always_comb begin
    fix_res = rem_fix;
    case (op_q)
      OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[PW-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    ex_hold_flag_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !kill_i) begin
          accept         = 1'b1;
          ex_hold_flag_o = 1'b1;
          state_d        = special ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        ex_hold_flag_o = 1'b1;
        if (kill_i)            state_d = ST_IDLE;
        else if (cnt_q == '0)  state_d = ST_FIX;
      end
      ST_FIX: begin
        ex_hold_flag_o = 1'b1;
        state_d        = kill_i ? ST_IDLE : ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_q      <= '0;
      rd_q      <= '0;
      opb_q     <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      rd_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q      <= op_i;
            rd_q      <= rd_addr_i;
            neg_res_q <= s1 ^ s2;
            neg_rem_q <= s1;
            cnt_q     <= CNT_W'(XLEN - 1);
            opb_q     <= op_i[2] ? abs2 : abs1;
            prod_q    <= {{XLEN{1'b0}}, (op_i[2] ? abs1 : abs2)};
            if (special) begin
              result_q  <= special_res;
              rd_addr_q <= rd_addr_i;
            end
          end
        end
        ST_CALC: begin
          prod_q <= op_q[2] ? div_next : mul_next;
          cnt_q  <= cnt_q - CNT_W'(1);
        end
        ST_FIX: begin
          if (!kill_i) begin
            result_q  <= fix_res;
            rd_addr_q <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  // A kill arriving in DONE suppresses the strobe so a flushed op never writes back
  assign result_valid_o = (state_q == ST_DONE) & ~kill_i;
  assign busy_o         = (state_q != ST_IDLE);
  assign result_o       = result_q;
  assign rd_addr_o      = rd_addr_q;

endmodule
